// File: rtl/obi_mem_arbiter_if.sv
// Bus bundle for the two-requester OBI arbiter: instruction (m0), data (m1) and shared memory side.
// The slave modport is the arbiter's view; master is the environment driving requesters and memory.
interface obi_mem_arbiter_if;
   logic        m0_req_i;
   logic        m0_gnt_o;
   logic [31:0] m0_addr_i;
   logic        m0_we_i;
   logic [3:0]  m0_be_i;
   logic [31:0] m0_wdata_i;
   logic        m0_rvalid_o;
   logic [31:0] m0_rdata_o;

   logic        m1_req_i;
   logic        m1_gnt_o;
   logic [31:0] m1_addr_i;
   logic        m1_we_i;
   logic [3:0]  m1_be_i;
   logic [31:0] m1_wdata_i;
   logic        m1_rvalid_o;
   logic [31:0] m1_rdata_o;

   logic        s_req_o;
   logic        s_gnt_i;
   logic [31:0] s_addr_o;
   logic        s_we_o;
   logic [3:0]  s_be_o;
   logic [31:0] s_wdata_o;
   logic        s_rvalid_i;
   logic [31:0] s_rdata_i;

   modport slave (
      input  m0_req_i, m0_addr_i, m0_we_i, m0_be_i, m0_wdata_i,
      output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
      input  m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i,
      output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
      output s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o,
      input  s_gnt_i, s_rvalid_i, s_rdata_i
   );

   modport master (
      output m0_req_i, m0_addr_i, m0_we_i, m0_be_i, m0_wdata_i,
      input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
      output m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i,
      input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
      input  s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o,
      output s_gnt_i, s_rvalid_i, s_rdata_i
   );
endinterface

// File: rtl/obi_mem_arbiter.sv
// Two-to-one OBI arbiter with zero-latency grant/response paths and an owner FIFO for response routing.
// Grant counters exist only when OBI_ARB_GRANT_STATS_EN is defined; otherwise both outputs are tied to 0.
module obi_mem_arbiter #(
   parameter int MAX_OUTSTANDING = 2,
   parameter int FIXED_PRIO      = 0
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   obi_mem_arbiter_if.slave   bus,
   output logic               rsp_err_o,
   output logic [31:0]        grant_cnt0_o,
   output logic [31:0]        grant_cnt1_o
);
   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t                     r_state;
   logic                       r_sel;
   logic                       r_last;
   logic [MAX_OUTSTANDING-1:0] r_fifo;
   logic [PW-1:0]              r_wr_ptr;
   logic [PW-1:0]              r_rd_ptr;
   logic [CW-1:0]              r_cnt;
   logic                       r_err;

   logic w_full;
   logic w_empty;
   logic w_winner;
   logic w_sel;
   logic w_s_req;
   logic w_push;
   logic w_pop;
   logic w_head;

   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
   endfunction

   assign w_full  = (r_cnt == CW'(MAX_OUTSTANDING));
   assign w_empty = (r_cnt == '0);

   // Winner encoding: 0 = instruction port, 1 = data port.
   always_comb begin
      w_winner = 1'b0;
      if (FIXED_PRIO != 0)
         w_winner = !bus.m0_req_i;
      else if (bus.m0_req_i && bus.m1_req_i)
         w_winner = !r_last;
      else
         w_winner = !bus.m0_req_i;
   end

   assign w_sel   = (r_state == HOLD) ? r_sel : w_winner;
   assign w_s_req = rst_ni && ((r_state == HOLD) ||
                    (!w_full && (bus.m0_req_i || bus.m1_req_i)));
   assign w_push  = w_s_req && bus.s_gnt_i;
   assign w_pop   = rst_ni && bus.s_rvalid_i && !w_empty;
   assign w_head  = r_fifo[r_rd_ptr];

   assign bus.s_req_o   = w_s_req;
   assign bus.s_addr_o  = w_sel ? bus.m1_addr_i  : bus.m0_addr_i;
   assign bus.s_we_o    = w_sel ? bus.m1_we_i    : bus.m0_we_i;
   assign bus.s_be_o    = w_sel ? bus.m1_be_i    : bus.m0_be_i;
   assign bus.s_wdata_o = w_sel ? bus.m1_wdata_i : bus.m0_wdata_i;

   assign bus.m0_gnt_o    = w_push && !w_sel;
   assign bus.m1_gnt_o    = w_push &&  w_sel;
   assign bus.m0_rvalid_o = w_pop  && !w_head;
   assign bus.m1_rvalid_o = w_pop  &&  w_head;
   assign bus.m0_rdata_o  = bus.s_rdata_i;
   assign bus.m1_rdata_o  = bus.s_rdata_i;
   assign rsp_err_o       = r_err;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= IDLE;
         r_sel    <= 1'b0;
         r_last   <= 1'b1;
         r_fifo   <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_s_req && !bus.s_gnt_i) begin
                  r_state <= HOLD;
                  r_sel   <= w_winner;
               end
            end
            HOLD: begin
               if (bus.s_gnt_i)
                  r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase

         if (w_push) begin
            r_fifo[r_wr_ptr] <= w_sel;
            r_wr_ptr         <= f_inc(r_wr_ptr);
            r_last           <= w_sel;
         end
         if (w_pop)
            r_rd_ptr <= f_inc(r_rd_ptr);
         r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);

         // A response with nothing outstanding is a protocol error; it stays latched.
         if (bus.s_rvalid_i && w_empty)
            r_err <= 1'b1;
      end
   end

`ifdef OBI_ARB_GRANT_STATS_EN
   logic [31:0] r_cnt0;
   logic [31:0] r_cnt1;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else begin
         if (bus.m0_gnt_o)
            r_cnt0 <= r_cnt0 + 32'd1;
         if (bus.m1_gnt_o)
            r_cnt1 <= r_cnt1 + 32'd1;
      end
   end

   assign grant_cnt0_o = r_cnt0;
   assign grant_cnt1_o = r_cnt1;
`else
   assign grant_cnt0_o = '0;
   assign grant_cnt1_o = '0;
`endif

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Directed bench: round-robin instance (a) and fixed-priority instance (b), hand-computed expectations.
module tb_obi_mem_arbiter;
   logic        clk;
   logic        rst_n;
   logic        err_a;
   logic        err_b;
   logic [31:0] cnt0_a;
   logic [31:0] cnt1_a;
   logic [31:0] cnt0_b;
   logic [31:0] cnt1_b;
   int          n_total;
   int          n_bad;

   obi_mem_arbiter_if bus_a();
   obi_mem_arbiter_if bus_b();

   obi_mem_arbiter #(.MAX_OUTSTANDING(2), .FIXED_PRIO(0)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus_a.slave),
      .rsp_err_o(err_a), .grant_cnt0_o(cnt0_a), .grant_cnt1_o(cnt1_a));

   obi_mem_arbiter #(.MAX_OUTSTANDING(2), .FIXED_PRIO(1)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus_b.slave),
      .rsp_err_o(err_b), .grant_cnt0_o(cnt0_b), .grant_cnt1_o(cnt1_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input logic g0, input logic g1, input logic v0, input logic v1);
      check({tag, "_gnt0"}, 32'(bus_a.m0_gnt_o), 32'(g0));
      check({tag, "_gnt1"}, 32'(bus_a.m1_gnt_o), 32'(g1));
      check({tag, "_rv0"},  32'(bus_a.m0_rvalid_o), 32'(v0));
      check({tag, "_rv1"},  32'(bus_a.m1_rvalid_o), 32'(v1));
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      rst_n   = 1'b0;
      bus_a.m0_req_i = 0; bus_a.m0_addr_i = 32'h100; bus_a.m0_we_i = 0;
      bus_a.m0_be_i = 4'hF; bus_a.m0_wdata_i = 32'h1111_1111;
      bus_a.m1_req_i = 0; bus_a.m1_addr_i = 32'h200; bus_a.m1_we_i = 1;
      bus_a.m1_be_i = 4'hC; bus_a.m1_wdata_i = 32'hDEAD_BEEF;
      bus_a.s_gnt_i = 0; bus_a.s_rvalid_i = 0; bus_a.s_rdata_i = 0;
      bus_b.m0_req_i = 0; bus_b.m0_addr_i = 32'h300; bus_b.m0_we_i = 0;
      bus_b.m0_be_i = 4'hF; bus_b.m0_wdata_i = 0;
      bus_b.m1_req_i = 0; bus_b.m1_addr_i = 32'h400; bus_b.m1_we_i = 0;
      bus_b.m1_be_i = 4'hF; bus_b.m1_wdata_i = 0;
      bus_b.s_gnt_i = 0; bus_b.s_rvalid_i = 0; bus_b.s_rdata_i = 0;

      // Reset: outputs stay quiet even with live inputs.
      bus_a.m0_req_i = 1; bus_a.s_gnt_i = 1; bus_a.s_rvalid_i = 1;
      @(negedge clk);
      check("rst_sreq", 32'(bus_a.s_req_o), 0);
      chk_a("rst", 0, 0, 0, 0);
      check("rst_err", 32'(err_a), 0);
      check("rst_cnt0", cnt0_a, 0);
      tick(); tick();
      bus_a.m0_req_i = 0; bus_a.s_gnt_i = 0; bus_a.s_rvalid_i = 0;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_err", 32'(err_a), 0);
      tick();

      // Round-robin under continuous requests; responses one cycle behind grants.
      for (int k = 0; k < 6; k++) begin
         bus_a.m0_req_i = 1; bus_a.m1_req_i = 1; bus_a.s_gnt_i = 1;
         bus_a.s_rvalid_i = (k > 0);
         bus_a.s_rdata_i  = 32'hA000 + k;
         @(negedge clk);
         check("rr_gnt0", 32'(bus_a.m0_gnt_o), 32'(k % 2 == 0));
         check("rr_gnt1", 32'(bus_a.m1_gnt_o), 32'(k % 2 == 1));
         check("rr_addr", bus_a.s_addr_o, (k % 2 == 1) ? 32'h200 : 32'h100);
         check("rr_wdata", bus_a.s_wdata_o, (k % 2 == 1) ? 32'hDEAD_BEEF : 32'h1111_1111);
         if (k > 0) begin
            check("rr_rv0", 32'(bus_a.m0_rvalid_o), 32'((k - 1) % 2 == 0));
            check("rr_rv1", 32'(bus_a.m1_rvalid_o), 32'((k - 1) % 2 == 1));
            check("rr_rdata1", bus_a.m1_rdata_o, 32'hA000 + k);
         end
         tick();
      end
      bus_a.m0_req_i = 0; bus_a.m1_req_i = 0; bus_a.s_gnt_i = 0;
      bus_a.s_rvalid_i = 1; bus_a.s_rdata_i = 32'hBEEF;
      @(negedge clk);
      chk_a("rr_drain", 0, 0, 0, 1);
      check("rr_rdata0", bus_a.m0_rdata_o, 32'hBEEF);
      tick();
      bus_a.s_rvalid_i = 0;
`ifdef OBI_ARB_GRANT_STATS_EN
      check("rr_cnt0", cnt0_a, 3);
      check("rr_cnt1", cnt1_a, 3);
`else
      check("rr_cnt0", cnt0_a, 0);
      check("rr_cnt1", cnt1_a, 0);
`endif

      // Held address phase: m1 locked while memory stalls; m0 joins later.
      bus_a.m1_addr_i = 32'h0000_1000; bus_a.m1_req_i = 1;
      for (int c = 0; c < 3; c++) begin
         if (c == 1) bus_a.m0_req_i = 1;
         @(negedge clk);
         check("hold_sreq", 32'(bus_a.s_req_o), 1);
         check("hold_addr", bus_a.s_addr_o, 32'h0000_1000);
         chk_a("hold", 0, 0, 0, 0);
         tick();
      end
      bus_a.s_gnt_i = 1;
      @(negedge clk);
      check("hold_gaddr", bus_a.s_addr_o, 32'h0000_1000);
      chk_a("hold_gnt", 0, 1, 0, 0);
      tick();
      bus_a.m1_req_i = 0;
      @(negedge clk);
      check("after_addr", bus_a.s_addr_o, 32'h100);
      chk_a("after", 1, 0, 0, 0);
      tick();

      // FIFO full (m1, m0 outstanding): requests blocked until a response pops.
      @(negedge clk);
      check("full_sreq", 32'(bus_a.s_req_o), 0);
      chk_a("full", 0, 0, 0, 0);
      tick();
      bus_a.s_rvalid_i = 1;
      @(negedge clk);
      check("full_pop_sreq", 32'(bus_a.s_req_o), 0);
      chk_a("full_pop", 0, 0, 0, 1);
      tick();
      @(negedge clk);
      check("pushpop_sreq", 32'(bus_a.s_req_o), 1);
      chk_a("pushpop", 1, 0, 1, 0);
      tick();
      bus_a.s_rvalid_i = 0;
      @(negedge clk);
      chk_a("refill", 1, 0, 0, 0);
      tick();
      @(negedge clk);
      check("refull_sreq", 32'(bus_a.s_req_o), 0);
      tick();
      bus_a.m0_req_i = 0; bus_a.s_gnt_i = 0; bus_a.s_rvalid_i = 1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk_a("drain2", 0, 0, 1, 0);
         tick();
      end

      // Spurious response with nothing outstanding.
      @(negedge clk);
      chk_a("spur", 0, 0, 0, 0);
      check("spur_err_pre", 32'(err_a), 0);
      tick();
      bus_a.s_rvalid_i = 0;
      tick(); tick();
      check("spur_err_sticky", 32'(err_a), 1);

      // Last grant went to m0, so the next tie favours m1.
      bus_a.m0_req_i = 1; bus_a.m1_req_i = 1; bus_a.s_gnt_i = 1;
      @(negedge clk);
      chk_a("tie1", 0, 1, 0, 0);
      tick();
      @(negedge clk);
      chk_a("tie2", 1, 0, 0, 0);
      tick();

      // Reset with two outstanding discards them.
      rst_n = 1'b0;
      #1;
      check("rst2_sreq", 32'(bus_a.s_req_o), 0);
      check("rst2_err", 32'(err_a), 0);
      chk_a("rst2", 0, 0, 0, 0);
      bus_a.m0_req_i = 0; bus_a.m1_req_i = 0; bus_a.s_gnt_i = 0;
      tick();
      rst_n = 1'b1;
      bus_a.s_rvalid_i = 1;
      @(negedge clk);
      chk_a("late_rv", 0, 0, 0, 0);
      check("late_err_pre", 32'(err_a), 0);
      tick();
      bus_a.s_rvalid_i = 0;
      check("late_err", 32'(err_a), 1);
      bus_a.m0_req_i = 1; bus_a.m1_req_i = 1; bus_a.s_gnt_i = 1;
      @(negedge clk);
      chk_a("tie_rst", 1, 0, 0, 0);
      tick();
      bus_a.m0_req_i = 0; bus_a.m1_req_i = 0; bus_a.s_gnt_i = 0;

      // Fixed priority: m0 wins every contested cycle.
      bus_b.m0_req_i = 1; bus_b.m1_req_i = 1; bus_b.s_gnt_i = 1;
      for (int k = 0; k < 4; k++) begin
         bus_b.s_rvalid_i = (k > 0);
         @(negedge clk);
         check("fp_gnt0", 32'(bus_b.m0_gnt_o), 1);
         check("fp_gnt1", 32'(bus_b.m1_gnt_o), 0);
         tick();
      end
      bus_b.m0_req_i = 0; bus_b.m1_req_i = 0; bus_b.s_gnt_i = 0;
      bus_b.s_rvalid_i = 1;
      @(negedge clk);
      check("fp_drain_rv0", 32'(bus_b.m0_rvalid_o), 1);
      tick();
      bus_b.s_rvalid_i = 0;
      check("fp_err", 32'(err_b), 0);
`ifdef OBI_ARB_GRANT_STATS_EN
      check("fp_cnt0", cnt0_b, 4);
`else
      check("fp_cnt0", cnt0_b, 0);
`endif
      check("fp_cnt1", cnt1_b, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
